// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution MAC datapath.
package conv_pkg;

    // Default geometry and number format: 5x5 kernel, Q8.8 words.
    localparam int KERNEL_SIZE_DEF = 5;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRAC_BITS_DEF   = 8;

    // Saturation limits at the default word width (0x7FFF / 0x8000).
    localparam longint SAT_MAX_DEF = (longint'(1) <<< (DATA_WIDTH_DEF - 1)) - 1;
    localparam longint SAT_MIN_DEF = -(longint'(1) <<< (DATA_WIDTH_DEF - 1));

    // Largest representable signed value for a given word width.
    function automatic longint sat_max(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    // Most negative representable signed value for a given word width.
    function automatic longint sat_min(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

    // Accumulator width: full product width plus tree growth for N+1 leaves,
    // plus one guard bit so the shifted bias can never wrap the sum.
    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n + 1) + 1;
    endfunction

endpackage

// File: rtl/adder_tree.sv
// Balanced adder tree over N products plus the aligned bias, then
// arithmetic shift back to Q format and saturation to the word range.
module adder_tree
    import conv_pkg::*;
#(
    parameter int N          = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic [N*2*DATA_WIDTH-1:0] products,
    input  logic [DATA_WIDTH-1:0]     bias,
    output logic [DATA_WIDTH-1:0]     result
);

    localparam int PW     = 2 * DATA_WIDTH;
    localparam int LEAVES = N + 1;
    localparam int DEPTH  = $clog2(LEAVES);
    localparam int ACC_W  = acc_width(DATA_WIDTH, N);

    localparam logic signed [ACC_W-1:0] MAX_A = ACC_W'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_W-1:0] MIN_A = ACC_W'(sat_min(DATA_WIDTH));

    // node[level][index]; level 0 holds the leaves, node[DEPTH][0] the sum.
    logic signed [ACC_W-1:0] node [DEPTH+1][LEAVES];
    logic signed [ACC_W-1:0] shifted;

    genvar gi, gl, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_leaf
            assign node[0][gi] = ACC_W'(signed'(products[gi*PW +: PW]));
        end
        // Bias is Q8.8; move it to the Q16.16 product scale.
        assign node[0][N] = ACC_W'(signed'(bias)) <<< FRAC_BITS;

        for (gl = 1; gl <= DEPTH; gl++) begin : g_level
            localparam int CNT_IN  = (LEAVES + (1 << (gl - 1)) - 1) >> (gl - 1);
            localparam int CNT_OUT = (CNT_IN + 1) / 2;
            for (gj = 0; gj < LEAVES; gj++) begin : g_node
                if (gj < CNT_OUT) begin : g_live
                    if (2 * gj + 1 < CNT_IN) begin : g_add
                        assign node[gl][gj] = node[gl-1][2*gj] + node[gl-1][2*gj+1];
                    end else begin : g_pass
                        // Odd node out at this level rides up unchanged.
                        assign node[gl][gj] = node[gl-1][2*gj];
                    end
                end else begin : g_idle
                    assign node[gl][gj] = '0;
                end
            end
        end
    endgenerate

    // Floor shift back to Q8.8, then clamp to the representable word range.
    always_comb begin
        shifted = node[DEPTH][0] >>> FRAC_BITS;
        result  = shifted[DATA_WIDTH-1:0];
        if (shifted > MAX_A) begin
            result = MAX_A[DATA_WIDTH-1:0];
        end else if (shifted < MIN_A) begin
            result = MIN_A[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/multiplier.sv
// N parallel signed lane multipliers, full-precision products, no rounding.
module multiplier
    import conv_pkg::*;
#(
    parameter int N          = KERNEL_SIZE_DEF * KERNEL_SIZE_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [N*DATA_WIDTH-1:0]   weights,
    input  logic [N*DATA_WIDTH-1:0]   pixel_data,
    output logic [N*2*DATA_WIDTH-1:0] products
);

    localparam int PW = 2 * DATA_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic signed [PW-1:0] w_ext;
            logic signed [PW-1:0] p_ext;
            // Sign-extend both operands first so the product is exact at PW bits.
            assign w_ext = PW'(signed'(weights[gi*DATA_WIDTH +: DATA_WIDTH]));
            assign p_ext = PW'(signed'(pixel_data[gi*DATA_WIDTH +: DATA_WIDTH]));
            assign products[gi*PW +: PW] = w_ext * p_ext;
        end
    endgenerate

endmodule

// File: rtl/conv_mac_datapath.sv
// Two-stage pipelined KxK convolution MAC: registered lane products,
// then registered saturated sum-plus-bias. No backpressure.
module conv_mac_datapath
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRAC_BITS   = FRAC_BITS_DEF
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       in_valid,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] pixel_data,
    input  logic [DATA_WIDTH-1:0]                      bias,
    output logic                                       out_valid,
    output logic [DATA_WIDTH-1:0]                      result
);

    localparam int N  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int PW = 2 * DATA_WIDTH;

    logic [N*PW-1:0]       prod_d;
    logic [N*PW-1:0]       prod_q;
    logic [DATA_WIDTH-1:0] bias_q;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] result_d;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  out_valid_q;

    multiplier #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_multiplier (
        .weights    (weights),
        .pixel_data (pixel_data),
        .products   (prod_d)
    );

    adder_tree #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_adder_tree (
        .products   (prod_q),
        .bias       (bias_q),
        .result     (result_d)
    );

    // Stage 1: capture products and bias only when a new operand set arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q     <= '0;
            bias_q     <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                prod_q <= prod_d;
                bias_q <= bias;
            end
        end
    end

    // Stage 2: register the saturated sum; result holds between valid beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q <= result_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_conv_mac_datapath.sv
// Directed, table-driven bench for conv_mac_datapath at default parameters.
module tb_conv_mac_datapath;

    localparam int N  = 25;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [N*DW-1:0] weights;
    logic [N*DW-1:0] pixel_data;
    logic [DW-1:0] bias;
    logic          out_valid;
    logic [DW-1:0] result;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    conv_mac_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .weights    (weights),
        .pixel_data (pixel_data),
        .bias       (bias),
        .out_valid  (out_valid),
        .result     (result)
    );

    typedef struct {
        string       name;
        logic [15:0] w_fill;
        logic [15:0] p_fill;
        int          lane;     // -1: no per-lane override
        logic [15:0] w_lane;
        logic [15:0] p_lane;
        logic [15:0] bias;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%04h, want 0x%04h", name, act, exp);
    endtask

    function automatic logic [N*DW-1:0] pack(input logic [15:0] fill, input int lane,
                                              input logic [15:0] lv);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = (i == lane) ? lv : fill;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        weights    = pack(v.w_fill, v.lane, v.w_lane);
        pixel_data = pack(v.p_fill, v.lane, v.p_lane);
        bias       = v.bias;
        in_valid   = 1'b1;
    endtask

    task automatic scramble();
        weights    = {N{16'hFFFF}};
        pixel_data = {N{16'h1234}};
        bias       = 16'h5A5A;
        in_valid   = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"ones_x_twos",  16'h0100, 16'h0200, -1, 16'h0000, 16'h0000, 16'h0000, 16'h3200};
        vecs[1]  = '{"neg_pix_bias", 16'h0100, 16'hFF00, -1, 16'h0000, 16'h0000, 16'h0180, 16'hE880};
        vecs[2]  = '{"sat_pos",      16'h7FFF, 16'h7FFF, -1, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF};
        vecs[3]  = '{"sat_neg",      16'h7FFF, 16'h8000, -1, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
        vecs[4]  = '{"trunc_pos",    16'h0000, 16'h0000,  0, 16'h0001, 16'h0080, 16'h0000, 16'h0000};
        vecs[5]  = '{"trunc_neg",    16'h0000, 16'h0000,  0, 16'h0001, 16'hFF80, 16'h0000, 16'hFFFF};
        vecs[6]  = '{"frac_mix",     16'h0080, 16'h0040, -1, 16'h0000, 16'h0000, 16'hFF00, 16'h0220};
        vecs[7]  = '{"lane0_bias",   16'h0000, 16'h0000,  0, 16'h0300, 16'h0200, 16'h0100, 16'h0700};
        vecs[8]  = '{"lane24",       16'h0000, 16'h0000, 24, 16'h0200, 16'h0300, 16'h0000, 16'h0600};
        vecs[9]  = '{"bias_max",     16'h0000, 16'h0000, -1, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
        vecs[10] = '{"bias_min",     16'h0000, 16'h0000, -1, 16'h0000, 16'h0000, 16'h8000, 16'h8000};
        vecs[11] = '{"below_min",    16'h0000, 16'h0000,  0, 16'h0001, 16'hFF00, 16'h8000, 16'h8000};
        vecs[12] = '{"above_max",    16'h0100, 16'h0100, -1, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};

        // Reset state, observed before any clock edge.
        reset      = 1'b1;
        in_valid   = 1'b0;
        weights    = '0;
        pixel_data = '0;
        bias       = '0;
        #1;
        check("reset_valid", {15'b0, out_valid}, 16'h0000);
        check("reset_result", result, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_valid", {15'b0, out_valid}, 16'h0000);

        // Single-shot vectors: latency, value and hold after the beat.
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            drive(vecs[k]);
            @(posedge clk);
            @(negedge clk);
            scramble();
            check({vecs[k].name, "_lat1"}, {15'b0, out_valid}, 16'h0000);
            @(posedge clk);
            @(negedge clk);
            check({vecs[k].name, "_valid"}, {15'b0, out_valid}, 16'h0001);
            check({vecs[k].name, "_result"}, result, vecs[k].exp);
            $display("vec %-12s result=0x%04h expected=0x%04h", vecs[k].name, result, vecs[k].exp);
            @(posedge clk);
            @(negedge clk);
            check({vecs[k].name, "_drop"}, {15'b0, out_valid}, 16'h0000);
            check({vecs[k].name, "_hold"}, result, vecs[k].exp);
        end

        // Back-to-back stream, then asynchronous reset mid-stream.
        @(negedge clk);
        drive(vecs[0]);
        @(negedge clk);
        check("b2b_lat1", {15'b0, out_valid}, 16'h0000);
        drive(vecs[1]);
        @(negedge clk);
        check("b2b_v0", {15'b0, out_valid}, 16'h0001);
        check("b2b_r0", result, 16'h3200);
        $display("b2b beat0 result=0x%04h", result);
        drive(vecs[5]);
        @(negedge clk);
        check("b2b_v1", {15'b0, out_valid}, 16'h0001);
        check("b2b_r1", result, 16'hE880);
        $display("b2b beat1 result=0x%04h", result);
        scramble();
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_valid", {15'b0, out_valid}, 16'h0000);
        check("async_rst_result", result, 16'h0000);
        $display("mid-stream reset out_valid=%0b result=0x%04h", out_valid, result);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_stale_valid", {15'b0, out_valid}, 16'h0000);
            check("no_stale_result", result, 16'h0000);
        end

        // First transaction after release keeps the two-cycle latency.
        @(negedge clk);
        drive(vecs[1]);
        @(negedge clk);
        scramble();
        check("post_rst_lat1", {15'b0, out_valid}, 16'h0000);
        @(negedge clk);
        check("post_rst_valid", {15'b0, out_valid}, 16'h0001);
        check("post_rst_result", result, 16'hE880);
        $display("post-reset result=0x%04h", result);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
